// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: instruction handshake and ALU operand/result bus of the issue stage.
//   in_inst/in_valid/in_ready : instruction (or immediate) byte handshake into the stage
//   alu_ra/alu_rb/alu_inst    : operands and instruction byte driven to the ALU
//   alu_rd/alu_flags          : combinational ALU result and registered ALU flags
//   modport slave is taken by the issue stage, master by whatever surrounds it.
interface alu_issue_stage_if;
  logic [7:0] in_inst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_ra;
  logic [7:0] alu_rb;
  logic [7:0] alu_inst;
  logic [7:0] alu_rd;
  logic [7:0] alu_flags;
  modport master (
    output in_inst, in_valid, alu_rd, alu_flags,
    input  in_ready, alu_ra, alu_rb, alu_inst
  );
  modport slave (
    input  in_inst, in_valid, alu_rd, alu_flags,
    output in_ready, alu_ra, alu_rb, alu_inst
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issues 8-bit instructions from a 4x8 register file to an external ALU and writes results back.
//   clk, rst_n (async active-low) : clock and reset
//   bus (alu_issue_stage_if.slave): instruction handshake and ALU operand/result bus
//   flags_q     : ALU flags committed one cycle after execute
//   busy        : stage is not idle
//   err_timeout : one-cycle pulse when an immediate byte never arrived
//   dbg_sel/dbg_data : combinational register-file read port
//   Define ALU_ISSUE_CMP_EN to decode opcode 0011 as CMP (SUB without writeback).
module alu_issue_stage #(
  parameter int unsigned IMM_TIMEOUT = 15,
  parameter logic [7:0]  REG_RESET   = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_issue_stage_if.slave        bus,
  output logic [7:0]              flags_q,
  output logic                    busy,
  output logic                    err_timeout,
  input  logic [1:0]              dbg_sel,
  output logic [7:0]              dbg_data
);
  typedef enum logic [1:0] {IDLE, IMM, EXEC, COMMIT} state_t;
  state_t     state;
  logic [7:0] r [4];
  logic [7:0] inst_q;
  logic [7:0] cnt;
  logic [1:0] ld_d;
  logic [3:0] op;
  logic       xfer;
  logic       is_alu;
  logic       is_cmp;
  logic [7:0] eff_inst;
  assign op           = bus.in_inst[7:4];
  assign bus.in_ready = state == IDLE || state == IMM;
  assign xfer         = bus.in_valid && bus.in_ready;
  assign busy         = state != IDLE;
  assign dbg_data     = r[dbg_sel];
`ifdef ALU_ISSUE_CMP_EN
  assign is_alu = op inside {4'h8, 4'h9, 4'hA, 4'hB, 4'h4, 4'h5, 4'h3};
  assign is_cmp = inst_q[7:4] == 4'h3;
`else
  assign is_alu = op inside {4'h8, 4'h9, 4'hA, 4'hB, 4'h4, 4'h5};
  assign is_cmp = 1'b0;
`endif
  // CMP runs through the ALU as a SUB so the flags match a subtraction
  assign eff_inst = is_cmp ? {4'hB, inst_q[3:0]} : inst_q;
  always_comb begin
    bus.alu_inst = (state == EXEC || state == COMMIT) ? eff_inst : 8'h00;
    bus.alu_ra   = state == EXEC ? r[inst_q[3:2]] : 8'h00;
    bus.alu_rb   = state == EXEC ? r[inst_q[1:0]] : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '{default: REG_RESET};
      flags_q     <= 8'h00;
      inst_q      <= 8'h00;
      cnt         <= 8'h00;
      ld_d        <= 2'd0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE:
          if (xfer) begin
            if (is_alu) begin
              inst_q <= bus.in_inst;
              state  <= EXEC;
            end else if (op == 4'h1) begin
              ld_d  <= bus.in_inst[3:2];
              cnt   <= 8'h00;
              state <= IMM;
            end else if (op == 4'h2)
              r[bus.in_inst[3:2]] <= r[bus.in_inst[1:0]];
          end
        // an immediate arriving on the timeout cycle wins over the abort
        IMM:
          if (xfer) begin
            r[ld_d] <= bus.in_inst;
            state   <= IDLE;
          end else if (cnt + 8'd1 == 8'(IMM_TIMEOUT)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else
            cnt <= cnt + 8'd1;
        EXEC: begin
          if (!is_cmp) r[inst_q[3:2]] <= bus.alu_rd;
          state <= COMMIT;
        end
        // the ALU registered its flags on the EXEC edge; take them now
        COMMIT: begin
          flags_q <= bus.alu_flags;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
